conv_kernel_sched_cxy: RTL and testbench
========================================

# conv_kernel_sched_cxy

Sequencer for one `conv_core_3x3_cxy` instance: for each of `N_KERNEL` output kernels it fetches nine weights plus a bias from a weight memory and holds them on the core's weight/bias inputs. It holds the core in reset while loading, releases it, and triggers the upstream feature-map reader to replay the input map. It then counts the core's output pixels until `LAST_PIX` and advances to the next kernel. It sits between the layer top (`START`/`DONE`), the weight RAM, the feature-map source and the conv core.

## Interface
- `DW`, 24, data width of weights, bias and memory words
- `P_WIDTH`, 64, feature-map width in pixels
- `P_HEIGHT`, 64, feature-map height in pixels
- `P_PIX_CNT_W`, 12, pixel-counter width; must hold `P_WIDTH*P_HEIGHT-1`
- `N_KERNEL`, 8, kernels per layer
- `KCNT_W`, 3, kernel-index width; must hold `N_KERNEL-1`
- `WADDR_W`, 7, weight-memory address width; must hold `N_KERNEL*10-1`

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `START` in 1: one-cycle start pulse; honoured only in IDLE.
- `ABORT` in 1: return to IDLE from any state.
- `WMEM_RD` out 1: weight-memory read strobe.
- `WMEM_ADDR` out `WADDR_W`: read address.
- `WMEM_DATA` in `DW`: read data, valid exactly 1 cycle after `WMEM_RD`.
- `CFG_W` out `9*DW`: W_11..W_33 packed, W_11 in the LSBs.
- `CFG_B` out `DW`: bias.
- `CORE_RSTn` out 1: active-low synchronous reset to the core.
- `CORE_VALID` in 1: core `VALID`.
- `CORE_LAST_PIX` in 1: core `LAST_PIX`.
- `SRC_START` out 1: one-cycle pulse; the feature-map source replays the full map.
- `KERNEL_IDX` out `KCNT_W`: current kernel.
- `PIX_CNT` out `P_PIX_CNT_W`: output pixels counted for the current kernel.
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse when the layer completes.
- `ERR` out 1: sticky pixel-count mismatch flag; cleared by `START` or `RST`.

## Operation
- States: IDLE, LOAD, ARM, RUN, NEXT, FIN.
- IDLE:
  - `CORE_RSTn`=0.
  - On `START`: clear `KERNEL_IDX`, `PIX_CNT` and `ERR`, then go to LOAD.
- LOAD:
  - `CORE_RSTn`=0.
  - Issue reads i=0..9 on consecutive cycles at `WMEM_ADDR = KERNEL_IDX*10 + i`.
  - Word returned for i<9 goes to `CFG_W[(i+1)*DW-1 : i*DW]`; word i=9 goes to `CFG_B`.
  - After the 10th word is captured, go to ARM.
- ARM:
  - Lasts 2 cycles with `CORE_RSTn`=1.
  - `SRC_START` pulses in the 2nd cycle, then go to RUN.
- RUN:
  - Each cycle with `CORE_VALID` increments `PIX_CNT`.
  - On `CORE_LAST_PIX`, set `ERR` if `CORE_VALID`=0 or `PIX_CNT` (pre-increment) ≠ `P_WIDTH*P_HEIGHT-1`, then go to NEXT.
- NEXT (1 cycle):
  - `CORE_RSTn`=0, `PIX_CNT` cleared.
  - If `KERNEL_IDX`==`N_KERNEL-1`, go to FIN; otherwise increment `KERNEL_IDX` and go to LOAD.
- FIN: `DONE`=1 for 1 cycle, then go to IDLE.
- `CFG_W`/`CFG_B` change only in LOAD and hold through IDLE.
- `ABORT` has priority over every transition, including a same-cycle `START`:
  - next state IDLE, `CORE_RSTn`=0, no `DONE`;
  - `CFG_*`, `KERNEL_IDX` and `ERR` keep their values;
  - an in-flight read return is discarded.
- `START` while `BUSY` is ignored.
- `CORE_VALID`/`CORE_LAST_PIX` outside RUN are ignored.

## Timing
- Reset values: `WMEM_RD`=0, `WMEM_ADDR`=0, `CFG_W`=0, `CFG_B`=0, `CORE_RSTn`=0, `SRC_START`=0, `KERNEL_IDX`=0, `PIX_CNT`=0, `BUSY`=0, `DONE`=0, `ERR`=0; state IDLE.
- All outputs are registered.
- `START` at cycle t:
  - LOAD occupies t+1..t+11 (`WMEM_RD` high t+1..t+10, last capture t+11);
  - ARM occupies t+12..t+13, with `SRC_START` at t+13;
  - RUN from t+14.
- Per-kernel overhead outside RUN: 14 cycles (NEXT + LOAD + ARM).
- `DONE` comes 2 cycles after the final `CORE_LAST_PIX`.
- Async `RST` mid-LOAD or mid-RUN forces reset values immediately; no partial `CFG` retained.

## Structure
- Shared package `cnn_cxy_pkg`:
  - state encoding constants;
  - `WORDS_PER_KERNEL`=10;
  - `ARM_CYCLES`=2.
- Natural sub-module: `weight_fetch_cxy`, holding the LOAD read issue/capture counters and the `CFG` shift-in registers, with `go`/`done` handshake.
- The main FSM stays in `conv_kernel_sched_cxy`.

## Test plan
Benches run with `P_WIDTH`=4, `P_HEIGHT`=4, `N_KERNEL`=2.
- Memory word = address+1, one `START`, model core emits 16 `VALID` with `LAST_PIX` on the 16th -> `CFG_W` word i = i+1, `CFG_B`=10; `SRC_START` at t+13; after kernel 1, `CFG_B`=20; `DONE` exactly once; `ERR`=0.
- Core `LAST_PIX` after only 15 `VALID` -> `ERR`=1 sticky through `DONE`; next `START` clears it.
- `ABORT` in LOAD cycle 5 -> IDLE next cycle, `CORE_RSTn`=0, no `DONE`, `BUSY`=0.
- `START` and `ABORT` in the same IDLE cycle -> remains IDLE.
- `START` during RUN -> ignored; `KERNEL_IDX` and `PIX_CNT` unaffected.
- Async `RST` asserted mid-RUN between clock edges -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/cnn_cxy_pkg.sv
// Shared definitions for the conv-layer kernel scheduler and its weight fetcher.
package cnn_cxy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_NEXT = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam int WORDS_PER_KERNEL = 10;
    localparam int ARM_CYCLES       = 2;

endpackage

// File: rtl/weight_fetch_cxy.sv
// Issues the ten weight-memory reads for one kernel and shifts the returned words
// into the core's weight/bias registers; done pulses on the tenth capture.
module weight_fetch_cxy
    import cnn_cxy_pkg::*;
#(
    parameter int DW      = 24,
    parameter int WADDR_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               abort,
    input  logic [WADDR_W-1:0] base,
    input  logic [DW-1:0]      data,
    output logic               rd,
    output logic [WADDR_W-1:0] addr,
    output logic [9*DW-1:0]    cfg_w,
    output logic [DW-1:0]      cfg_b,
    output logic               done
);

    localparam int CNT_W = $clog2(WORDS_PER_KERNEL + 1);
    localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(WORDS_PER_KERNEL);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_KERNEL - 1);

    logic [CNT_W-1:0]               issue_cnt;
    logic [CNT_W-1:0]               cap_cnt;
    logic                           cap_vld;
    logic [WORDS_PER_KERNEL*DW-1:0] words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd        <= 1'b0;
            addr      <= '0;
            issue_cnt <= '0;
        end else if (abort) begin
            rd        <= 1'b0;
            issue_cnt <= '0;
        end else if (go) begin
            rd        <= 1'b1;
            addr      <= base;
            issue_cnt <= CNT_W'(1);
        end else if (rd) begin
            if (issue_cnt == ISSUE_END) begin
                rd <= 1'b0;
            end else begin
                addr      <= addr + WADDR_W'(1);
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
        end
    end

    // Words arrive in address order, so shifting in from the top leaves word 0
    // in the LSBs and the bias in the top slot after the tenth capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld <= 1'b0;
            cap_cnt <= '0;
            words   <= '0;
        end else if (abort) begin
            cap_vld <= 1'b0;
            cap_cnt <= '0;
        end else begin
            cap_vld <= rd;
            if (cap_vld) begin
                words   <= {data, words[WORDS_PER_KERNEL*DW-1:DW]};
                cap_cnt <= (cap_cnt == LAST_WORD) ? '0 : cap_cnt + CNT_W'(1);
            end
        end
    end

    assign done  = cap_vld && (cap_cnt == LAST_WORD);
    assign cfg_w = words[9*DW-1:0];
    assign cfg_b = words[WORDS_PER_KERNEL*DW-1:9*DW];

endmodule

// File: rtl/conv_kernel_sched_cxy.sv
// Per-kernel sequencer for one 3x3 conv core: loads weights, arms the core,
// replays the input map and counts output pixels until the last one.
module conv_kernel_sched_cxy
    import cnn_cxy_pkg::*;
#(
    parameter int DW          = 24,
    parameter int P_WIDTH     = 64,
    parameter int P_HEIGHT    = 64,
    parameter int P_PIX_CNT_W = 12,
    parameter int N_KERNEL    = 8,
    parameter int KCNT_W      = 3,
    parameter int WADDR_W     = 7
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   ABORT,
    output logic                   WMEM_RD,
    output logic [WADDR_W-1:0]     WMEM_ADDR,
    input  logic [DW-1:0]          WMEM_DATA,
    output logic [9*DW-1:0]        CFG_W,
    output logic [DW-1:0]          CFG_B,
    output logic                   CORE_RSTn,
    input  logic                   CORE_VALID,
    input  logic                   CORE_LAST_PIX,
    output logic                   SRC_START,
    output logic [KCNT_W-1:0]      KERNEL_IDX,
    output logic [P_PIX_CNT_W-1:0] PIX_CNT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);

    localparam logic [P_PIX_CNT_W-1:0] PIX_LAST  = P_PIX_CNT_W'(P_WIDTH * P_HEIGHT - 1);
    localparam logic [KCNT_W-1:0]      KIDX_LAST = KCNT_W'(N_KERNEL - 1);
    localparam logic [1:0]             ARM_LAST  = 2'(ARM_CYCLES - 1);
    localparam logic [1:0]             ARM_SRC   = 2'(ARM_CYCLES - 2);

    state_t               state;
    state_t               next_state;
    logic                 go;
    logic [WADDR_W-1:0]   base;
    logic                 fetch_done;
    logic [1:0]           arm_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    // A fetch is launched from IDLE for kernel 0 and from NEXT for the following kernel.
    always_comb begin
        next_state = state;
        go         = 1'b0;
        base       = '0;
        case (state)
            ST_IDLE: if (START) begin
                next_state = ST_LOAD;
                go         = 1'b1;
            end
            ST_LOAD: if (fetch_done) next_state = ST_ARM;
            ST_ARM:  if (arm_cnt == ARM_LAST) next_state = ST_RUN;
            ST_RUN:  if (CORE_LAST_PIX) next_state = ST_NEXT;
            ST_NEXT: begin
                if (KERNEL_IDX == KIDX_LAST) begin
                    next_state = ST_FIN;
                end else begin
                    next_state = ST_LOAD;
                    go         = 1'b1;
                    base       = WADDR_W'(KERNEL_IDX + KCNT_W'(1)) * WADDR_W'(WORDS_PER_KERNEL);
                end
            end
            ST_FIN:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (ABORT) begin
            next_state = ST_IDLE;
            go         = 1'b0;
        end
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            CORE_RSTn <= 1'b0;
            SRC_START <= 1'b0;
            arm_cnt   <= '0;
        end else begin
            BUSY      <= (next_state != ST_IDLE);
            DONE      <= (next_state == ST_FIN);
            CORE_RSTn <= (next_state == ST_ARM) || (next_state == ST_RUN);
            SRC_START <= (state == ST_ARM) && (next_state == ST_ARM) && (arm_cnt == ARM_SRC);
            arm_cnt   <= ((state == ST_ARM) && (next_state == ST_ARM)) ? arm_cnt + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            KERNEL_IDX <= '0;
            PIX_CNT    <= '0;
            ERR        <= 1'b0;
        end else if (!ABORT) begin
            case (state)
                ST_IDLE: if (START) begin
                    KERNEL_IDX <= '0;
                    PIX_CNT    <= '0;
                    ERR        <= 1'b0;
                end
                ST_RUN: begin
                    if (CORE_VALID) PIX_CNT <= PIX_CNT + P_PIX_CNT_W'(1);
                    if (CORE_LAST_PIX && (!CORE_VALID || PIX_CNT != PIX_LAST)) ERR <= 1'b1;
                end
                ST_NEXT: begin
                    PIX_CNT <= '0;
                    if (KERNEL_IDX != KIDX_LAST) KERNEL_IDX <= KERNEL_IDX + KCNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    weight_fetch_cxy #(
        .DW      (DW),
        .WADDR_W (WADDR_W)
    ) u_fetch (
        .clk   (CLK),
        .rst   (RST),
        .go    (go),
        .abort (ABORT),
        .base  (base),
        .data  (WMEM_DATA),
        .rd    (WMEM_RD),
        .addr  (WMEM_ADDR),
        .cfg_w (CFG_W),
        .cfg_b (CFG_B),
        .done  (fetch_done)
    );

endmodule

// File: tb/tb_conv_kernel_sched_cxy.sv
// Self-checking bench for conv_kernel_sched_cxy: table-driven control vectors,
// directed layer runs and randomized layers against a behavioural layer model.
module tb_conv_kernel_sched_cxy;

    localparam int DW   = 24;
    localparam int PW   = 4;
    localparam int PH   = 4;
    localparam int PCW  = 12;
    localparam int NK   = 2;
    localparam int KW   = 3;
    localparam int AW   = 7;
    localparam int NPIX = PW * PH;

    logic            CLK = 1'b0;
    logic            RST;
    logic            START;
    logic            ABORT;
    logic [DW-1:0]   WMEM_DATA;
    logic            CORE_VALID;
    logic            CORE_LAST_PIX;
    logic            WMEM_RD;
    logic [AW-1:0]   WMEM_ADDR;
    logic [9*DW-1:0] CFG_W;
    logic [DW-1:0]   CFG_B;
    logic            CORE_RSTn;
    logic            SRC_START;
    logic [KW-1:0]   KERNEL_IDX;
    logic [PCW-1:0]  PIX_CNT;
    logic            BUSY;
    logic            DONE;
    logic            ERR;

    conv_kernel_sched_cxy #(
        .DW(DW), .P_WIDTH(PW), .P_HEIGHT(PH), .P_PIX_CNT_W(PCW),
        .N_KERNEL(NK), .KCNT_W(KW), .WADDR_W(AW)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .WMEM_RD(WMEM_RD), .WMEM_ADDR(WMEM_ADDR), .WMEM_DATA(WMEM_DATA),
        .CFG_W(CFG_W), .CFG_B(CFG_B), .CORE_RSTn(CORE_RSTn),
        .CORE_VALID(CORE_VALID), .CORE_LAST_PIX(CORE_LAST_PIX),
        .SRC_START(SRC_START), .KERNEL_IDX(KERNEL_IDX), .PIX_CNT(PIX_CNT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit start;
        bit abort;
        bit exp_busy;
        bit exp_rd;
        bit exp_rstn;
    } vec_t;

    logic [DW-1:0] mem [0:127];
    logic          rd_s;
    logic [AW-1:0] addr_s;
    int            checks;
    int            passes;
    int            cyc;
    int            done_cnt;
    int            src_cnt;
    bit            err_model;
    int            kern_nv [NK];
    bit            kern_lv [NK];

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: the memory model answers the read seen before the edge.
    task automatic tick();
        rd_s   = WMEM_RD;
        addr_s = WMEM_ADDR;
        @(posedge CLK);
        #1;
        cyc++;
        WMEM_DATA = rd_s ? mem[addr_s] : '0;
        if (DONE) done_cnt++;
        if (SRC_START) src_cnt++;
    endtask

    task automatic apply_stimulus(input bit start, input bit abort);
        START = start;
        ABORT = abort;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_rd"},    WMEM_RD,    0);
        check_output({tag, "_addr"},  WMEM_ADDR,  0);
        check_output({tag, "_cfgw"},  CFG_W,      0);
        check_output({tag, "_cfgb"},  CFG_B,      0);
        check_output({tag, "_rstn"},  CORE_RSTn,  0);
        check_output({tag, "_src"},   SRC_START,  0);
        check_output({tag, "_kidx"},  KERNEL_IDX, 0);
        check_output({tag, "_pix"},   PIX_CNT,    0);
        check_output({tag, "_busy"},  BUSY,       0);
        check_output({tag, "_done"},  DONE,       0);
        check_output({tag, "_err"},   ERR,        0);
    endtask

    // Runs one layer using kern_nv/kern_lv as the core's behaviour per kernel.
    task automatic run_layer(input bit start_mid);
        int t;
        int r;
        int waited;
        int cnt;
        int gap;
        logic [9*DW-1:0] exp_w;
        err_model = 1'b0;
        done_cnt  = 0;
        t = cyc;
        apply_stimulus(1'b1, 1'b0);
        check_output("start_busy", BUSY, 1);
        check_output("start_rd", WMEM_RD, 1);
        check_output("start_addr", WMEM_ADDR, 0);
        check_output("start_err_clr", ERR, 0);
        check_output("start_kidx", KERNEL_IDX, 0);
        r = 0;
        for (int k = 0; k < NK; k++) begin
            waited = 0;
            while (!SRC_START && waited < 40) begin
                CORE_VALID    = 1'($urandom_range(0, 1));
                CORE_LAST_PIX = 1'($urandom_range(0, 1));
                tick();
                waited++;
            end
            if (!SRC_START) begin
                check_output("src_timeout", 0, 1);
                CORE_VALID    = 1'b0;
                CORE_LAST_PIX = 1'b0;
                return;
            end
            check_output("src_time", cyc, (k == 0) ? t + 13 : r + 14);
            for (int i = 0; i < 9; i++) exp_w[i*DW +: DW] = mem[k*10 + i];
            check_output("cfg_w", CFG_W, exp_w);
            check_output("cfg_b", CFG_B, mem[k*10 + 9]);
            check_output("arm_kidx", KERNEL_IDX, k);
            check_output("arm_rstn", CORE_RSTn, 1);
            CORE_VALID    = 1'b1;
            CORE_LAST_PIX = 1'b0;
            tick();
            check_output("arm_valid_ignored", PIX_CNT, 0);
            cnt = 0;
            for (int i = 0; i < kern_nv[k]; i++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    CORE_VALID    = 1'b0;
                    CORE_LAST_PIX = 1'b0;
                    tick();
                    check_output("pix_gap", PIX_CNT, cnt);
                end
                CORE_VALID    = 1'b1;
                CORE_LAST_PIX = (i == kern_nv[k] - 1) && kern_lv[k];
                START         = start_mid && (k == 0) && (i == 5);
                r = cyc;
                tick();
                START = 1'b0;
                cnt++;
                if (!CORE_LAST_PIX) begin
                    check_output("pix_cnt", PIX_CNT, cnt);
                    check_output("run_kidx", KERNEL_IDX, k);
                end
            end
            if (!kern_lv[k]) begin
                CORE_VALID    = 1'b0;
                CORE_LAST_PIX = 1'b1;
                r = cyc;
                tick();
            end
            CORE_VALID    = 1'b0;
            CORE_LAST_PIX = 1'b0;
            if (!kern_lv[k] || kern_nv[k] - 1 != NPIX - 1) err_model = 1'b1;
        end
        waited = 0;
        while (!DONE && waited < 10) begin
            tick();
            waited++;
        end
        check_output("done_time", cyc, r + 2);
        check_output("done_err", ERR, err_model);
        repeat (4) tick();
        check_output("done_once", done_cnt, 1);
        check_output("end_busy", BUSY, 0);
        check_output("end_rstn", CORE_RSTn, 0);
        check_output("end_err", ERR, err_model);
        check_output("end_cfg_b", CFG_B, mem[(NK-1)*10 + 9]);
    endtask

    initial begin
        vec_t vecs [5];
        int   t;
        checks = 0;
        passes = 0;
        cyc    = 0;
        done_cnt = 0;
        src_cnt  = 0;
        RST = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        CORE_VALID = 1'b0;
        CORE_LAST_PIX = 1'b0;
        WMEM_DATA = '0;
        for (int a = 0; a < 128; a++) mem[a] = DW'(a + 1);

        tick();
        tick();
        check_reset_values("rst");
        RST = 1'b0;
        tick();

        // START+ABORT together, idle, start, abort in first LOAD cycle, idle.
        vecs[0] = '{start: 1'b1, abort: 1'b1, exp_busy: 1'b0, exp_rd: 1'b0, exp_rstn: 1'b0};
        vecs[1] = '{start: 1'b0, abort: 1'b0, exp_busy: 1'b0, exp_rd: 1'b0, exp_rstn: 1'b0};
        vecs[2] = '{start: 1'b1, abort: 1'b0, exp_busy: 1'b1, exp_rd: 1'b1, exp_rstn: 1'b0};
        vecs[3] = '{start: 1'b0, abort: 1'b1, exp_busy: 1'b0, exp_rd: 1'b0, exp_rstn: 1'b0};
        vecs[4] = '{start: 1'b0, abort: 1'b0, exp_busy: 1'b0, exp_rd: 1'b0, exp_rstn: 1'b0};
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].start, vecs[i].abort);
            check_output("vec_busy", BUSY, vecs[i].exp_busy);
            check_output("vec_rd", WMEM_RD, vecs[i].exp_rd);
            check_output("vec_rstn", CORE_RSTn, vecs[i].exp_rstn);
        end

        $display("[TB] directed layer, START during RUN");
        kern_nv[0] = 16; kern_lv[0] = 1'b1;
        kern_nv[1] = 16; kern_lv[1] = 1'b1;
        run_layer(1'b1);

        $display("[TB] short kernel sets ERR");
        kern_nv[0] = 15; kern_lv[0] = 1'b1;
        run_layer(1'b0);

        $display("[TB] ABORT in LOAD cycle 5");
        done_cnt = 0;
        src_cnt  = 0;
        apply_stimulus(1'b1, 1'b0);
        check_output("abort_err_clr", ERR, 0);
        repeat (4) tick();
        apply_stimulus(1'b0, 1'b1);
        check_output("abort_busy", BUSY, 0);
        check_output("abort_rstn", CORE_RSTn, 0);
        check_output("abort_rd", WMEM_RD, 0);
        repeat (20) tick();
        check_output("abort_no_done", done_cnt, 0);
        check_output("abort_no_src", src_cnt, 0);
        check_output("abort_kidx", KERNEL_IDX, 0);

        $display("[TB] async reset mid-RUN");
        t = cyc;
        apply_stimulus(1'b1, 1'b0);
        while (!SRC_START && cyc < t + 40) tick();
        check_output("arst_src", SRC_START, 1);
        tick();
        CORE_VALID = 1'b1;
        repeat (3) tick();
        check_output("arst_pre_pix", PIX_CNT, 3);
        #3 RST = 1'b1;
        #1 check_reset_values("arst");
        @(posedge CLK);
        #1;
        cyc++;
        RST = 1'b0;
        CORE_VALID = 1'b0;
        tick();
        check_output("arst_after_busy", BUSY, 0);
        check_output("arst_after_cfg", CFG_W, 0);

        $display("[TB] randomized layers");
        for (int n = 0; n < 4; n++) begin
            for (int a = 0; a < NK*10; a++) mem[a] = DW'($urandom());
            for (int k = 0; k < NK; k++) begin
                case ($urandom_range(0, 5))
                    0:       kern_nv[k] = 15;
                    1:       kern_nv[k] = 17;
                    default: kern_nv[k] = 16;
                endcase
                kern_lv[k] = ($urandom_range(0, 4) != 0);
            end
            run_layer(n[0]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
